lsf_peak_select: RTL and testbench
==================================

// Module: lsf_peak_select
// PURPOSE
//  Downstream of the per-theta r-bin histogram stage in the LSF (Legendre segment finder).
//  - Latches each theta slice's local-max (rbin, count) pulses during an event window.
//  - At event end, scans all slices sequentially and selects the global (theta, rbin) peak.
//  - Emits the peak over a valid/ready handshake.
//  - Drives the clear pulse that resets every histogram between events.
// PARAMETERS
//  NTHETA      128  number of theta slices / histogram instances
//  THETA_WIDTH 7    theta index width; NTHETA <= 2**THETA_WIDTH
//  RBIN_WIDTH  8    histogram r-bin width incl. sign; rbin field is RBIN_WIDTH-1 bits
//  CNT_WIDTH   4    hit-count width
//  MIN_HITS    3    minimum count for a peak to be flagged as found
// PORTS
//  clk              in   1                       clock
//  rst_n            in   1                       synchronous, active-low reset
//  event_start      in   1                       pulse: open a new event window
//  event_end        in   1                       pulse: close window, start scan
//  lmax_vld         in   NTHETA                  per-slice local-max valid
//  lmax_rbin        in   NTHETA*(RBIN_WIDTH-1)   per-slice local-max rbin; slice i at [i*(RBIN_WIDTH-1)+:RBIN_WIDTH-1]
//  lmax_count       in   NTHETA*CNT_WIDTH        per-slice local-max count; slice i at [i*CNT_WIDTH+:CNT_WIDTH]
//  reset_rbins      out  1                       one-cycle clear to all histograms
//  busy             out  1                       high in SCAN or RESULT
//  peak_vld         out  1                       result valid
//  peak_rdy         in   1                       consumer ready
//  peak_found       out  1                       best count >= MIN_HITS
//  peak_theta       out  THETA_WIDTH             theta index of peak
//  peak_rbin        out  RBIN_WIDTH-1            rbin of peak
//  peak_count       out  CNT_WIDTH               count of peak
//  err_dropped      out  1                       sticky: event_start/event_end dropped while busy
// BEHAVIOUR
//  Reset
//   - All outputs 0; state IDLE; table cleared (count=0, rbin=0 for every slice).
//   - Reset mid-scan or mid-result aborts with no output; err_dropped cleared.
//  FSM: IDLE -> COLLECT -> SCAN -> RESULT -> IDLE
//   - IDLE: event_start -> COLLECT, reset_rbins=1 next cycle, table cleared.
//     event_end in IDLE is ignored and is not counted as an error.
//   - COLLECT: for each slice i with lmax_vld[i] and lmax_count[i] > tbl_cnt[i], latch rbin and count.
//     All slices update in parallel. Equal counts do not overwrite, so the first rbin reached wins.
//   - COLLECT + event_start (with or without event_end): restart; clear table, pulse reset_rbins, stay in COLLECT.
//   - COLLECT + event_end only: -> SCAN. lmax_vld arriving in that same cycle is still latched.
//   - SCAN: idx 0..NTHETA-1, one slice per cycle.
//     A slice replaces best only if tbl_cnt[idx] > best_cnt (strict), so ties resolve to the lowest theta.
//     best starts at count 0, theta 0, rbin 0. After idx==NTHETA-1 -> RESULT.
//   - RESULT: peak_vld=1. Outputs are registered and stable until handshake.
//     peak_found = (best_cnt >= MIN_HITS). If no slice was hit: found=0, count=0, theta=0.
//     On peak_vld & peak_rdy: -> IDLE next cycle with reset_rbins=1 and table cleared.
//   - SCAN/RESULT: lmax_vld is ignored.
//     event_start or event_end sets err_dropped (sticky until rst_n) and is otherwise ignored.
//  Latency
//   - event_end accepted in cycle T: SCAN occupies T+1..T+NTHETA; peak_vld first high at T+NTHETA+1.
//  Handshake
//   - peak_vld never drops without peak_rdy; outputs do not change while peak_vld & !peak_rdy.
//  Width and control
//   - Count compares are unsigned CNT_WIDTH. Counts are never incremented here, so there is no wrap.
//   - reset_rbins is a registered one-cycle pulse; it is never high on two consecutive cycles
//     unless restarts arrive on consecutive cycles.
//   - busy = (state==SCAN) | (state==RESULT).
// STRUCTURE
//  lsf_pkg
//   - typedef lsf_peak_t {theta, rbin, count}; enum lsf_psel_state_t {IDLE, COLLECT, SCAN, RESULT}.
//   - LSF_RBIN_WIDTH and LSF_CNT_WIDTH constants, shared with the histogram stage.
//  Hierarchy
//   - Table is an array of NTHETA lsf_peak_t registers indexed by a THETA_WIDTH counter.
//   - One natural sub-module: lsf_peak_cmp, the registered strict-greater compare/replace of best vs. candidate.
// TESTING
//  1 Single track: start; slice 37 pulses (rbin 12, cnt 1..5); end -> peak_vld at T+129, theta 37, rbin 12, count 5, found 1.
//  2 Tie: slices 10 and 90 both reach count 4 -> theta 10 reported; reset_rbins pulses once after handshake.
//  3 Below threshold: best count 2 -> peak_vld with found 0, count 2. Empty event -> found 0, count 0, theta 0.
//  4 Backpressure: hold peak_rdy=0 for 20 cycles -> outputs stable, no reset_rbins; release -> IDLE in 1 cycle.
//  5 Restart and errors: event_start mid-COLLECT -> table cleared and reset_rbins pulse.
//    event_start during SCAN -> ignored, err_dropped=1, result unaffected.
//  6 rst_n low mid-SCAN -> all outputs 0, state IDLE, next event processed correctly.

Source files
------------

// File: rtl/lsf_pkg.sv
// Shared LSF types and widths used by the histogram stage and the peak selector.
package lsf_pkg;

  localparam int LSF_NTHETA      = 128;
  localparam int LSF_THETA_WIDTH = 7;
  localparam int LSF_RBIN_WIDTH  = 8;
  // Stored rbin field drops the histogram's sign bit.
  localparam int LSF_RBIN_FIELD  = LSF_RBIN_WIDTH - 1;
  localparam int LSF_CNT_WIDTH   = 4;
  localparam int LSF_MIN_HITS    = 3;

  typedef struct packed {
    logic [LSF_THETA_WIDTH-1:0] theta;
    logic [LSF_RBIN_FIELD-1:0]  rbin;
    logic [LSF_CNT_WIDTH-1:0]   count;
  } lsf_peak_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SCAN    = 2'd2,
    RESULT  = 2'd3
  } lsf_psel_state_t;

endpackage

// File: rtl/lsf_peak_select_if.sv
// Peak result channel from the peak selector to its consumer.
// Handshake: peak_vld rises when a result is ready and then holds, with
// found/theta/rbin/count stable, until a clock edge where peak_vld & peak_rdy
// are both high; that edge is the transfer. peak_rdy may toggle freely.
interface lsf_peak_select_if;
  import lsf_pkg::*;

  logic                       peak_vld;
  logic                       peak_rdy;
  logic                       peak_found;
  logic [LSF_THETA_WIDTH-1:0] peak_theta;
  logic [LSF_RBIN_FIELD-1:0]  peak_rbin;
  logic [LSF_CNT_WIDTH-1:0]   peak_count;

  modport master (
    output peak_vld, peak_found, peak_theta, peak_rbin, peak_count,
    input  peak_rdy
  );

  modport slave (
    input  peak_vld, peak_found, peak_theta, peak_rbin, peak_count,
    output peak_rdy
  );

endinterface

// File: rtl/lsf_peak_cmp.sv
// Running-best register: takes the candidate only when its count is strictly
// greater, so the earliest candidate wins any tie.
module lsf_peak_cmp
  import lsf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      en,
  input  lsf_peak_t cand,
  output lsf_peak_t best
);

  // Clear to count 0 / theta 0 / rbin 0, then keep the strictly larger count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      best <= '0;
    end else if (en && (cand.count > best.count)) begin
      best <= cand;
    end
  end

endmodule

// File: rtl/lsf_peak_select.sv
// LSF peak selector: latches per-theta local maxima during an event window,
// scans the table one slice per cycle at event end, and offers the global peak.
module lsf_peak_select
  import lsf_pkg::*;
#(
  parameter int NTHETA   = LSF_NTHETA,
  parameter int MIN_HITS = LSF_MIN_HITS
)
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             event_start,
  input  logic                             event_end,
  input  logic [NTHETA-1:0]                lmax_vld,
  input  logic [NTHETA*LSF_RBIN_FIELD-1:0] lmax_rbin,
  input  logic [NTHETA*LSF_CNT_WIDTH-1:0]  lmax_count,
  output logic                             reset_rbins,
  output logic                             busy,
  output logic                             err_dropped,
  output lsf_psel_state_t                  dbg_state,
  lsf_peak_select_if.master                peak_bus
);

  localparam logic [LSF_THETA_WIDTH-1:0] THETA_LAST = LSF_THETA_WIDTH'(NTHETA - 1);
  localparam logic [LSF_CNT_WIDTH-1:0]   MIN_CNT    = LSF_CNT_WIDTH'(MIN_HITS);

  lsf_psel_state_t            state, state_nxt;
  logic [LSF_THETA_WIDTH-1:0] idx;
  logic [LSF_RBIN_FIELD-1:0]  tbl_rbin [NTHETA];
  logic [LSF_CNT_WIDTH-1:0]   tbl_cnt  [NTHETA];
  logic                       restart, start_scan, handshake;
  logic                       collect_en, scan_en, drop, tbl_clear;
  lsf_peak_t                  cand, best;

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    start_scan = 1'b0;
    handshake  = 1'b0;
    collect_en = 1'b0;
    scan_en    = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (event_start) begin
          restart   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (event_start) begin
          restart = 1'b1;
        end else begin
          // The closing cycle still latches its local maxima.
          collect_en = 1'b1;
          if (event_end) begin
            start_scan = 1'b1;
            state_nxt  = SCAN;
          end
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        drop    = event_start | event_end;
        if (idx == THETA_LAST) state_nxt = RESULT;
      end
      RESULT: begin
        drop = event_start | event_end;
        if (peak_bus.peak_rdy) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tbl_clear = restart | handshake;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scan index walks 0..NTHETA-1 during SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n || start_scan) idx <= '0;
    else if (scan_en)         idx <= idx + 1'b1;
  end

  // One-cycle histogram clear, issued on every table clear.
  always_ff @(posedge clk) begin
    if (!rst_n) reset_rbins <= 1'b0;
    else        reset_rbins <= tbl_clear;
  end

  // Sticky flag for event pulses that arrive while the selector is busy.
  always_ff @(posedge clk) begin
    if (!rst_n)    err_dropped <= 1'b0;
    else if (drop) err_dropped <= 1'b1;
  end

  // Per-slice table: keep the first rbin that reaches each new higher count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NTHETA; i++) begin
      if (!rst_n || tbl_clear) begin
        tbl_rbin[i] <= '0;
        tbl_cnt[i]  <= '0;
      end else if (collect_en && lmax_vld[i] &&
                   (lmax_count[i*LSF_CNT_WIDTH +: LSF_CNT_WIDTH] > tbl_cnt[i])) begin
        tbl_rbin[i] <= lmax_rbin[i*LSF_RBIN_FIELD +: LSF_RBIN_FIELD];
        tbl_cnt[i]  <= lmax_count[i*LSF_CNT_WIDTH +: LSF_CNT_WIDTH];
      end
    end
  end

  assign cand.theta = idx;
  assign cand.rbin  = tbl_rbin[idx];
  assign cand.count = tbl_cnt[idx];

  lsf_peak_cmp u_cmp (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_scan | handshake),
    .en    (scan_en),
    .cand  (cand),
    .best  (best)
  );

  // Result is only presented in RESULT; payload is zero otherwise.
  assign peak_bus.peak_vld   = (state == RESULT);
  assign peak_bus.peak_found = peak_bus.peak_vld & (best.count >= MIN_CNT);
  assign peak_bus.peak_theta = peak_bus.peak_vld ? best.theta : '0;
  assign peak_bus.peak_rbin  = peak_bus.peak_vld ? best.rbin  : '0;
  assign peak_bus.peak_count = peak_bus.peak_vld ? best.count : '0;

  assign busy      = (state == SCAN) | (state == RESULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_lsf_peak_select.sv
// Bench for lsf_peak_select: table of hand-derived events, hand sequences for
// restart/error/reset corners, and random events against a table model.
module tb_lsf_peak_select;
  import lsf_pkg::*;

  localparam int NT = LSF_NTHETA;
  localparam int RF = LSF_RBIN_FIELD;
  localparam int CW = LSF_CNT_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             event_start, event_end;
  logic [NT-1:0]    lmax_vld;
  logic [NT*RF-1:0] lmax_rbin;
  logic [NT*CW-1:0] lmax_count;
  logic             reset_rbins, busy, err_dropped;
  lsf_psel_state_t  dbg_state;

  lsf_peak_select_if pb ();

  lsf_peak_select dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_start (event_start),
    .event_end   (event_end),
    .lmax_vld    (lmax_vld),
    .lmax_rbin   (lmax_rbin),
    .lmax_count  (lmax_count),
    .reset_rbins (reset_rbins),
    .busy        (busy),
    .err_dropped (err_dropped),
    .dbg_state   (dbg_state),
    .peak_bus    (pb)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference table: per slice, the highest count seen and the first rbin that reached it.
  int m_cnt  [NT];
  int m_rbin [NT];

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_cnt[i]  = 0;
      m_rbin[i] = 0;
    end
  endtask

  task automatic model_cycle();
    for (int i = 0; i < NT; i++) begin
      if (lmax_vld[i] && int'(lmax_count[i*CW +: CW]) > m_cnt[i]) begin
        m_cnt[i]  = int'(lmax_count[i*CW +: CW]);
        m_rbin[i] = int'(lmax_rbin[i*RF +: RF]);
      end
    end
  endtask

  // Global peak: largest count, then the lowest theta holding it; nothing hit -> zeros.
  task automatic model_expect(output int ef, output int et, output int er, output int ec);
    int maxc;
    maxc = 0;
    for (int i = 0; i < NT; i++) if (m_cnt[i] > maxc) maxc = m_cnt[i];
    et = 0;
    er = 0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (maxc > 0 && m_cnt[i] == maxc) begin
        et = i;
        er = m_rbin[i];
      end
    end
    ec = maxc;
    ef = (maxc >= LSF_MIN_HITS) ? 1 : 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lmax_vld   = '0;
    lmax_rbin  = '0;
    lmax_count = '0;
    event_end  = 1'b0;
  endtask

  task automatic start_event();
    event_start = 1'b1;
    tick();
    event_start = 1'b0;
    model_clear();
    check("start_reset_rbins", 32'(reset_rbins), 32'd1);
    check("start_state", 32'(dbg_state), 32'(COLLECT));
  endtask

  task automatic pulse(input int th, input int rb, input int ct, input bit with_end);
    clear_inputs();
    lmax_vld[th]             = 1'b1;
    lmax_rbin[th*RF +: RF]   = RF'(rb);
    lmax_count[th*CW +: CW]  = CW'(ct);
    event_end                = with_end;
    model_cycle();
    tick();
    clear_inputs();
  endtask

  // Called right after the edge that accepted event_end.
  task automatic finish_and_check(input int ef, input int et, input int er, input int ec,
                                  input int hold, input bit inject);
    int n;
    logic [19:0] exp_payload;
    n = 0;
    check("scan_busy", 32'(busy), 32'd1);
    check("scan_state", 32'(dbg_state), 32'(SCAN));
    while (!pb.peak_vld && n < 400) begin
      if (inject && n == 0) event_start = 1'b1;
      tick();
      event_start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(NT));
    check("peak_found", 32'(pb.peak_found), 32'(ef));
    check("peak_theta", 32'(pb.peak_theta), 32'(et));
    check("peak_rbin", 32'(pb.peak_rbin), 32'(er));
    check("peak_count", 32'(pb.peak_count), 32'(ec));
    check("result_busy", 32'(busy), 32'd1);
    if (inject) check("err_dropped_set", 32'(err_dropped), 32'd1);
    exp_payload = {1'b1, 1'(ef), 7'(et), 7'(er), 4'(ec)};
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_payload", 32'({pb.peak_vld, pb.peak_found, pb.peak_theta,
                                 pb.peak_rbin, pb.peak_count}), 32'(exp_payload));
      check("hold_no_clear", 32'(reset_rbins), 32'd0);
    end
    pb.peak_rdy = 1'b1;
    tick();
    pb.peak_rdy = 1'b0;
    check("post_hs_vld", 32'(pb.peak_vld), 32'd0);
    check("post_hs_clear", 32'(reset_rbins), 32'd1);
    check("post_hs_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check("clear_one_cycle", 32'(reset_rbins), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int t0, r0, c0;
    int t1, r1, c1;
    int t2, r2, c2;   // applied together with event_end
    int ef, et, er, ec;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int ef, et, er, ec, ncyc, nh, s;

    vecs[0] = '{37, 20, 3,   37, 12, 5,   37, 30, 5,    1, 37, 12, 5};  // equal count keeps first rbin
    vecs[1] = '{10,  7, 4,   90,  3, 4,   50,  1, 2,    1, 10,  7, 4};  // tie -> lowest theta
    vecs[2] = '{ 5,  9, 2,    6,  1, 1,    7,  0, 0,    0,  5,  9, 2};  // below threshold
    vecs[3] = '{ 3,  4, 0,  100,  2, 0,  127,  1, 0,    0,  0,  0, 0};  // empty event
    vecs[4] = '{127,127,15,   0,  5,14,    1,  2,15,    1,  1,  2,15};  // max count, edge slices
    vecs[5] = '{64,100, 3,   64, 50, 2,  127,126, 1,    1, 64,100, 3};  // exactly MIN_HITS
    vecs[6] = '{ 2, 10, 3,    2, 11, 4,    2, 12, 3,    1,  2, 11, 4};  // count rises then falls

    rst_n       = 1'b0;
    event_start = 1'b0;
    pb.peak_rdy = 1'b0;
    clear_inputs();
    model_clear();
    repeat (3) tick();

    check("rst_vld", 32'(pb.peak_vld), 32'd0);
    check("rst_payload", 32'({pb.peak_found, pb.peak_theta, pb.peak_rbin, pb.peak_count}), 32'd0);
    check("rst_flags", 32'({reset_rbins, busy, err_dropped}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // event_end while idle is ignored and not an error.
    event_end = 1'b1;
    tick();
    event_end = 1'b0;
    check("idle_end_state", 32'(dbg_state), 32'(IDLE));
    check("idle_end_err", 32'(err_dropped), 32'd0);
    check("idle_end_clear", 32'(reset_rbins), 32'd0);

    // Table-driven events; vector 1 also exercises long backpressure.
    for (int v = 0; v < 7; v++) begin
      start_event();
      pulse(vecs[v].t0, vecs[v].r0, vecs[v].c0, 1'b0);
      check("clear_dropped", 32'(reset_rbins), 32'd0);
      pulse(vecs[v].t1, vecs[v].r1, vecs[v].c1, 1'b0);
      pulse(vecs[v].t2, vecs[v].r2, vecs[v].c2, 1'b1);
      finish_and_check(vecs[v].ef, vecs[v].et, vecs[v].er, vecs[v].ec,
                       (v == 1) ? 20 : (v % 3), 1'b0);
    end

    // Restart mid-collect; a local max in the restart cycle is discarded.
    start_event();
    pulse(20, 5, 9, 1'b0);
    clear_inputs();
    lmax_vld[21]          = 1'b1;
    lmax_rbin[21*RF +: RF] = RF'(6);
    lmax_count[21*CW +: CW] = CW'(12);
    event_start = 1'b1;
    tick();
    event_start = 1'b0;
    clear_inputs();
    model_clear();
    check("restart_clear", 32'(reset_rbins), 32'd1);
    check("restart_state", 32'(dbg_state), 32'(COLLECT));
    pulse(30, 4, 3, 1'b1);
    check("restart_clear_drop", 32'(reset_rbins), 32'd0);
    finish_and_check(1, 30, 4, 3, 0, 1'b0);

    // event_start during SCAN: flagged, result unaffected, flag is sticky.
    start_event();
    pulse(45, 33, 7, 1'b1);
    finish_and_check(1, 45, 33, 7, 2, 1'b1);
    check("err_sticky", 32'(err_dropped), 32'd1);

    // Reset in the middle of a scan aborts with no output.
    start_event();
    pulse(70, 8, 6, 1'b1);
    repeat (10) tick();
    check("midscan_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_vld", 32'(pb.peak_vld), 32'd0);
    check("abort_flags", 32'({reset_rbins, busy, err_dropped}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    start_event();
    pulse(71, 9, 5, 1'b1);
    finish_and_check(1, 71, 9, 5, 1, 1'b0);

    // Random events against the reference table.
    for (int e = 0; e < 10; e++) begin
      start_event();
      ncyc = $urandom_range(1, 12);
      for (int c = 0; c < ncyc; c++) begin
        clear_inputs();
        nh = $urandom_range(0, 5);
        for (int h = 0; h < nh; h++) begin
          s = $urandom_range(0, NT - 1);
          lmax_vld[s]            = 1'b1;
          lmax_rbin[s*RF +: RF]  = RF'($urandom_range(0, 127));
          lmax_count[s*CW +: CW] = CW'($urandom_range(0, 15));
        end
        event_end = (c == ncyc - 1);
        model_cycle();
        tick();
        clear_inputs();
      end
      model_expect(ef, et, er, ec);
      finish_and_check(ef, et, er, ec, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
